axi_dmem_bridge: RTL and testbench



---
 rtl/axi_dmem_bridge_if.sv | 39 +++
 rtl/axi_dmem_bridge.sv | 178 +++++++++++++++++
 tb/tb_axi_dmem_bridge.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dmem_bridge_if.sv
// AXI4-Lite slave-side bundle for the data-memory bridge.
// Slave modport faces the bridge; master faces the requester.
interface axi_dmem_bridge_if #(
  parameter int ADDR_W  = 10,
  parameter int WIDTH   = 32,
  parameter int NUM_COL = 4
);
  logic [ADDR_W-1:0]  awaddr;
  logic               awvalid;
  logic               awready;
  logic [WIDTH-1:0]   wdata;
  logic [NUM_COL-1:0] wstrb;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [ADDR_W-1:0]  araddr;
  logic               arvalid;
  logic               arready;
  logic [WIDTH-1:0]   rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_dmem_bridge.sv
// AXI4-Lite to data-memory B-port bridge, one transaction at a time.
// Optional AXI_DMEM_ALIGN_CHECK_EN: unaligned accesses get SLVERR.
module axi_dmem_bridge #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 256,
  parameter int NUM_COL   = 4,
  parameter int COL_WIDTH = 8,
  localparam int ADDR_W   = $clog2(SIZE) + 2
) (
  input  logic               clk,
  input  logic               reset,
  axi_dmem_bridge_if.slave   s_axi,
  output logic [ADDR_W-1:0]  dmem_byte_addr,
  output logic [WIDTH-1:0]   dmem_data_out,
  output logic [NUM_COL-1:0] dmem_byte_wr_en,
  input  logic [WIDTH-1:0]   dmem0_data_in,
  input  logic [WIDTH-1:0]   dmem1_data_in,
  input  logic [WIDTH-1:0]   dmem2_data_in,
  input  logic [WIDTH-1:0]   dmem3_data_in
);

  typedef enum logic [2:0] {
    IDLE, W_EXEC, W_RESP, R_ADDR, R_CAP, R_RESP
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef logic [NUM_COL-1:0][COL_WIDTH-1:0] lanes_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  lanes_t             data_q, data_d;
  logic [NUM_COL-1:0] wen_q, wen_d;
  logic               err_q, err_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [WIDTH-1:0]   bank_word;
  logic               wr_hs, rd_hs;
  logic               aw_err, ar_err;

  // Writes need both AW and W together and win over reads.
  assign wr_hs = (state_q == IDLE) &&
                 s_axi.awvalid && s_axi.wvalid;
  assign rd_hs = (state_q == IDLE) && s_axi.arvalid &&
                 !(s_axi.awvalid && s_axi.wvalid);

`ifdef AXI_DMEM_ALIGN_CHECK_EN
  assign aw_err = |s_axi.awaddr[1:0];
  assign ar_err = |s_axi.araddr[1:0];
`else
  logic unused_lsb;
  assign unused_lsb = ^{s_axi.awaddr[1:0],
                        s_axi.araddr[1:0]};
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign s_axi.awready   = wr_hs;
  assign s_axi.wready    = wr_hs;
  assign s_axi.arready   = rd_hs;
  assign s_axi.bvalid    = bvalid_q;
  assign s_axi.bresp     = bresp_q;
  assign s_axi.rvalid    = rvalid_q;
  assign s_axi.rresp     = rresp_q;
  assign s_axi.rdata     = rdata_q;
  assign dmem_byte_addr  = addr_q;
  assign dmem_data_out   = data_q;
  assign dmem_byte_wr_en = wen_q;

  // State and all registered outputs; reset abandons any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      wen_q    <= '0;
      err_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state sequencing of one write or one read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_hs)      state_d = W_EXEC;
        else if (rd_hs) state_d = R_ADDR;
      end
      W_EXEC: state_d = W_RESP;
      W_RESP: if (s_axi.bready) state_d = IDLE;
      R_ADDR: state_d = R_CAP;
      R_CAP:  state_d = R_RESP;
      R_RESP: if (s_axi.rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Returning bank chosen by the top two address bits.
  always_comb begin
    bank_word = dmem0_data_in;
    unique case (addr_q[ADDR_W-1 -: 2])
      2'd0: bank_word = dmem0_data_in;
      2'd1: bank_word = dmem1_data_in;
      2'd2: bank_word = dmem2_data_in;
      2'd3: bank_word = dmem3_data_in;
      default: bank_word = dmem0_data_in;
    endcase
  end

  // Next values of the registered bus drives and responses.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wen_d    = '0;
    err_d    = err_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (wr_hs) begin
          addr_d = {s_axi.awaddr[ADDR_W-1:2], 2'b00};
          data_d = s_axi.wdata;
          err_d  = aw_err;
          wen_d  = aw_err ? '0 : s_axi.wstrb;
        end else if (rd_hs) begin
          addr_d = {s_axi.araddr[ADDR_W-1:2], 2'b00};
          err_d  = ar_err;
        end
      end
      W_EXEC: begin
        bvalid_d = 1'b1;
        bresp_d  = err_q ? SLVERR : OKAY;
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_d = 1'b0;
          bresp_d  = OKAY;
        end
      end
      R_CAP: begin
        rvalid_d = 1'b1;
        rresp_d  = err_q ? SLVERR : OKAY;
        rdata_d  = err_q ? '0 : bank_word;
      end
      R_RESP: begin
        if (s_axi.rready) begin
          rvalid_d = 1'b0;
          rresp_d  = OKAY;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_dmem_bridge.sv
// Bench for axi_dmem_bridge with a four-bank synchronous memory model.
// Responses and write pulses are checked against a scoreboard.
module tb_axi_dmem_bridge;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_dmem_bridge_if #(.ADDR_W(AW), .WIDTH(32), .NUM_COL(4)) s_axi ();

  logic [AW-1:0] dmem_byte_addr;
  logic [31:0]   dmem_data_out;
  logic [3:0]    dmem_byte_wr_en;
  logic [31:0]   d0, d1, d2, d3;

  axi_dmem_bridge #(
    .WIDTH(32), .SIZE(256), .NUM_COL(4), .COL_WIDTH(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_axi           (s_axi),
    .dmem_byte_addr  (dmem_byte_addr),
    .dmem_data_out   (dmem_data_out),
    .dmem_byte_wr_en (dmem_byte_wr_en),
    .dmem0_data_in   (d0),
    .dmem1_data_in   (d1),
    .dmem2_data_in   (d2),
    .dmem3_data_in   (d3)
  );

  // Four banks, 64 words each, byte-write, synchronous read-first.
  logic [31:0] mem [4][64];
  bit          preload;
  logic [1:0]  bk;
  logic [5:0]  wd;
  assign bk = dmem_byte_addr[9:8];
  assign wd = dmem_byte_addr[7:2];

  always @(posedge clk) begin
    if (preload) begin
      for (int b = 0; b < 4; b++)
        for (int w = 0; w < 64; w++)
          mem[b][w] <= (w == 0) ? 32'(b) : 32'hCAFE0000;
    end else begin
      for (int k = 0; k < 4; k++)
        if (dmem_byte_wr_en[k])
          mem[bk][wd][8*k +: 8] <= dmem_data_out[8*k +: 8];
    end
    d0 <= mem[0][wd];
    d1 <= mem[1][wd];
    d2 <= mem[2][wd];
    d3 <= mem[3][wd];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    s;
  } wr_t;

  typedef struct {
    bit          rd;
    logic [31:0] d;
    logic [1:0]  r;
  } rsp_t;

  wr_t  wq[$];
  rsp_t rq[$];
  wr_t  mw;
  rsp_t mr;

  // Scoreboard monitor: write pulses and B/R handshakes.
  always @(negedge clk) begin
    if (!reset) begin
      if (dmem_byte_wr_en != 4'h0) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", {dmem_byte_addr, dmem_byte_wr_en}, 0);
        end else begin
          mw = wq.pop_front();
          chk("wr_pulse",
              {dmem_byte_addr, dmem_data_out, dmem_byte_wr_en},
              {mw.a, mw.d, mw.s});
        end
      end
      if (s_axi.bvalid && s_axi.bready) begin
        if (rq.size() == 0) begin
          chk("b_unexpected", {s_axi.bvalid, s_axi.bresp}, 0);
        end else begin
          mr = rq.pop_front();
          chk("b_rsp", {1'b0, s_axi.bresp}, {mr.rd, mr.r});
        end
      end
      if (s_axi.rvalid && s_axi.rready) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", {s_axi.rvalid, s_axi.rdata}, 0);
        end else begin
          mr = rq.pop_front();
          chk("r_rsp", {1'b1, s_axi.rresp, s_axi.rdata},
              {mr.rd, mr.r, mr.d});
        end
      end
    end
  end

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    wr_t e;
    e.a = {a[AW-1:2], 2'b00};
    e.d = d;
    e.s = s;
    wq.push_back(e);
  endtask

  task automatic push_rsp(input bit rd, input logic [31:0] d,
                          input logic [1:0] r);
    rsp_t e;
    e.rd = rd;
    e.d  = d;
    e.r  = r;
    rq.push_back(e);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (rq.size() == 0 && wq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", {63'd0, done}, 64'd1);
    if (!done) begin
      wq.delete();
      rq.delete();
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] resp,
                           input bit pulse);
    bit ok = 1'b0;
    if (pulse) push_wr(a, d, s);
    push_rsp(1'b0, 32'h0, resp);
    @(posedge clk);
    #1;
    s_axi.awaddr  = a;
    s_axi.wdata   = d;
    s_axi.wstrb   = s;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_axi.awready && s_axi.wready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("aw_accept", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    drain();
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [1:0] resp);
    bit ok = 1'b0;
    push_rsp(1'b1, d, resp);
    @(posedge clk);
    #1;
    s_axi.araddr  = a;
    s_axi.arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_axi.arready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ar_accept", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
    s_axi.arvalid = 1'b0;
    drain();
  endtask

  typedef struct {
    bit            rd;
    logic [AW-1:0] a;
    logic [31:0]   wdat;
    logic [3:0]    s;
    logic [31:0]   rexp;
  } vec_t;

  vec_t tv[12];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1'b1, 10'h000, 32'h0,        4'h0, 32'h0};
    tv[1]  = '{1'b1, 10'h100, 32'h0,        4'h0, 32'h1};
    tv[2]  = '{1'b1, 10'h200, 32'h0,        4'h0, 32'h2};
    tv[3]  = '{1'b1, 10'h300, 32'h0,        4'h0, 32'h3};
    tv[4]  = '{1'b0, 10'h208, 32'h11223344, 4'h5, 32'h0};
    tv[5]  = '{1'b1, 10'h208, 32'h0,        4'h0, 32'hCA220044};
    tv[6]  = '{1'b0, 10'h30C, 32'h55667788, 4'h0, 32'h0};
    tv[7]  = '{1'b1, 10'h30C, 32'h0,        4'h0, 32'hCAFE0000};
    tv[8]  = '{1'b0, 10'h3FC, 32'hFFFFFFFF, 4'hF, 32'h0};
    tv[9]  = '{1'b1, 10'h3FC, 32'h0,        4'h0, 32'hFFFFFFFF};
    tv[10] = '{1'b1, 10'h0FC, 32'h0,        4'h0, 32'hCAFE0000};
    tv[11] = '{1'b1, 10'h104, 32'h0,        4'h0, 32'hDEADBEEF};

    reset         = 1'b1;
    preload       = 1'b1;
    s_axi.awaddr  = '0;
    s_axi.awvalid = 1'b0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.wvalid  = 1'b0;
    s_axi.bready  = 1'b1;
    s_axi.araddr  = '0;
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    @(negedge clk);
    chk("rst_hs", {s_axi.awready, s_axi.wready, s_axi.arready,
                   s_axi.bvalid, s_axi.rvalid}, 0);
    chk("rst_resp", {s_axi.bresp, s_axi.rresp, s_axi.rdata}, 0);
    chk("rst_bus", {dmem_byte_addr, dmem_data_out, dmem_byte_wr_en}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Write 0x104 with exact cycle timing, then read it back.
    push_wr(10'h104, 32'hDEADBEEF, 4'hF);
    push_rsp(1'b0, 32'h0, 2'b00);
    @(posedge clk);
    #1;
    s_axi.awaddr  = 10'h104;
    s_axi.wdata   = 32'hDEADBEEF;
    s_axi.wstrb   = 4'hF;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    @(negedge clk);
    chk("w_t0_ready", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b110);
    chk("w_t0_wen", dmem_byte_wr_en, 4'h0);
    @(posedge clk);
    #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    @(negedge clk);
    chk("w_t1_bus", {dmem_byte_addr, dmem_byte_wr_en, s_axi.bvalid},
        {10'h104, 4'hF, 1'b0});
    chk("w_t1_ready", {s_axi.awready, s_axi.arready}, 0);
    @(negedge clk);
    chk("w_t2", {s_axi.bvalid, s_axi.bresp, dmem_byte_wr_en},
        {1'b1, 2'b00, 4'h0});
    @(posedge clk);
    #1;
    push_rsp(1'b1, 32'hDEADBEEF, 2'b00);
    s_axi.araddr  = 10'h104;
    s_axi.arvalid = 1'b1;
    @(negedge clk);
    chk("w_t3_idle", {s_axi.bvalid, s_axi.arready}, 2'b01);
    @(posedge clk);
    #1;
    s_axi.arvalid = 1'b0;
    @(negedge clk);
    chk("r_t1", {dmem_byte_addr, dmem_byte_wr_en, s_axi.rvalid},
        {10'h104, 4'h0, 1'b0});
    @(negedge clk);
    chk("r_t2", s_axi.rvalid, 1'b0);
    @(negedge clk);
    chk("r_t3", {s_axi.rvalid, s_axi.rresp, s_axi.rdata},
        {1'b1, 2'b00, 32'hDEADBEEF});
    @(negedge clk);
    chk("r_t4", s_axi.rvalid, 1'b0);
    drain();

    for (int i = 0; i < 12; i++) begin
      if (tv[i].rd)
        axi_read(tv[i].a, tv[i].rexp, 2'b00);
      else
        axi_write(tv[i].a, tv[i].wdat, tv[i].s, 2'b00,
                  tv[i].s != 4'h0);
    end

    // B back-pressure with a competing read, write wins first.
    push_wr(10'h010, 32'h0BADF00D, 4'hF);
    push_rsp(1'b0, 32'h0, 2'b00);
    push_rsp(1'b1, 32'hDEADBEEF, 2'b00);
    @(posedge clk);
    #1;
    s_axi.bready  = 1'b0;
    s_axi.awaddr  = 10'h010;
    s_axi.wdata   = 32'h0BADF00D;
    s_axi.wstrb   = 4'hF;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    s_axi.araddr  = 10'h104;
    s_axi.arvalid = 1'b1;
    @(negedge clk);
    chk("prio_ready", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b110);
    @(posedge clk);
    #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    @(negedge clk);
    chk("prio_t1_ar", s_axi.arready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {s_axi.bvalid, s_axi.bresp, s_axi.arready,
                      s_axi.awready}, {1'b1, 2'b00, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1;
    s_axi.bready = 1'b1;
    @(negedge clk);
    chk("bp_release_ar", {s_axi.bvalid, s_axi.arready}, 2'b10);
    @(negedge clk);
    chk("prio_read_acc", {s_axi.bvalid, s_axi.arready}, 2'b01);
    @(posedge clk);
    #1;
    s_axi.arvalid = 1'b0;
    drain();

    // Reset during W_EXEC abandons the write.
    @(posedge clk);
    #1;
    s_axi.awaddr  = 10'h020;
    s_axi.wdata   = 32'h12345678;
    s_axi.wstrb   = 4'hF;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    @(negedge clk);
    chk("rst_w_acc", {s_axi.awready, s_axi.wready}, 2'b11);
    @(posedge clk);
    #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    chk("rst_w_exec", dmem_byte_wr_en, 4'hF);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_wen", {dmem_byte_wr_en, s_axi.bvalid}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold", {s_axi.bvalid, dmem_byte_wr_en}, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_b", {s_axi.bvalid, dmem_byte_wr_en}, 0);
    end
    axi_read(10'h020, 32'hCAFE0000, 2'b00);
    axi_write(10'h020, 32'h12345678, 4'hF, 2'b00, 1'b1);
    axi_read(10'h020, 32'h12345678, 2'b00);

    // Unaligned address handling.
`ifdef AXI_DMEM_ALIGN_CHECK_EN
    axi_write(10'h006, 32'h99999999, 4'hF, 2'b10, 1'b0);
    axi_read(10'h006, 32'h0, 2'b10);
    axi_read(10'h004, 32'hCAFE0000, 2'b00);
`else
    axi_write(10'h006, 32'h99999999, 4'hF, 2'b00, 1'b1);
    axi_read(10'h006, 32'h99999999, 2'b00);
    axi_read(10'h004, 32'h99999999, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
